mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter for the single-port instruction/data memory of the multicycle CPU. Two requesters share the memory: the instruction-fetch port and the data (load/store) port. The block inserts the memory's fixed wait states itself, so the control unit issues a request and waits for a one-cycle `done` instead of spending explicit wait states. Access order between the two ports is decided by round-robin arbitration.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LATENCY`, 3, cycles `mem_addr` is held before `mem_rdata` is sampled; legal range 1..15
- `WRITE_CYCLES`, 2, cycles `mem_wr` is held for a store; legal range 1..15

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  instruction-fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_done`  out  1  one-cycle completion pulse for the fetch port
- `if_rdata`  out  DATA_W  last fetched word (registered)
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_done`  out  1  one-cycle completion pulse for the data port
- `d_rdata`  out  DATA_W  last loaded word (registered)
- `mem_addr`  out  ADDR_W  memory address (registered)
- `mem_wdata`  out  DATA_W  memory write data (registered)
- `mem_wr`  out  1  memory read/write select: 1 = write, 0 = read
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  high in ACCESS and DONE
- `state_out`  out  2  FSM state encoding: IDLE=0, ACCESS=1, DONE=2

## Operation
- **Reset values.** When `reset` is low:
  - state = IDLE, counter = 0, `last_grant` = data port;
  - `mem_addr`, `mem_wdata` and both `rdata` registers = 0;
  - `mem_wr`, `if_done`, `d_done` and `busy` = 0.
- **IDLE**
  - If any `req` is high, capture owner, address, `we` and `wdata` into registers, clear the counter, and go to ACCESS.
  - When only one port requests, that port is granted.
  - When both request, the port not in `last_grant` is granted. After reset this means fetch wins the first tie.
  - `last_grant` updates to the granted owner.
  - `if_we` does not exist; a fetch is always a read.
- **ACCESS**
  - `mem_addr` and `mem_wdata` carry the captured values.
  - `mem_wr` = 1 for a data store, 0 otherwise.
  - The counter increments every cycle.
  - Terminal count is `MEM_LATENCY`-1 for reads and `WRITE_CYCLES`-1 for writes.
  - On the terminal cycle of a read, `mem_rdata` is clocked into the owner's `rdata` register. The other port's `rdata` is untouched.
  - Next state is DONE.
- **DONE**
  - The owner's `done` = 1 for exactly this cycle. `mem_wr` = 0.
  - `mem_addr` holds its value.
  - Next state is IDLE.
- **Requester rule**
  - Hold `req`, `addr`, `we` and `wdata` stable from assertion until `done` is seen.
  - Deassert `req` no later than the cycle after `done`.
  - `req` still high in the IDLE cycle after DONE is a new request.
- **Outputs are registered.** `mem_wr` is a register bit and never glitches.
- **Stores leave `rdata` unchanged.** A store does not modify either `rdata` register.
- **Requests while busy.** A request arriving while the block is busy is not lost. It waits in its `req` until IDLE; there is no queue.
- **Request withdrawn mid-access** (illegal). The access still completes and `done` still pulses.
- **Reset mid-access.**
  - The block returns to IDLE immediately and `mem_wr` drops asynchronously.
  - No `done` is issued; a partial write is possible.
  - A still-asserted `req` is served after reset is released.

## Timing
- **Read latency:** `req` first sampled in IDLE at cycle 0; ACCESS occupies cycles 1..`MEM_LATENCY`; `done` is high in cycle `MEM_LATENCY`+1. Default: 4.
- **Write latency:** `done` is high in cycle `WRITE_CYCLES`+1. Default: 3.
- **Throughput:** with back-to-back requests, one IDLE cycle separates consecutive accesses. A read occupies the port for `MEM_LATENCY`+2 cycles.
- **Tie grant:** the loser of a tie is granted in the IDLE cycle immediately after the winner's DONE, provided its `req` is still high.
- **`rdata` validity:** the new `rdata` value is visible in the same cycle `done` is high. It holds until that port's next read completes.
- **Boundary case:** `MEM_LATENCY`=1 gives exactly one ACCESS cycle, with `mem_rdata` sampled at the end of it.

## Test plan
- **Reset values:** drive `reset` low, then high, with no requests -> all outputs 0, `state_out`=0, `busy`=0 indefinitely.
- **Single fetch:** `if_req`=1, `if_addr`=0x10, memory returns 0xDEADBEEF -> `mem_addr`=0x10 and `mem_wr`=0 during cycles 1..3; `if_done` high only in cycle 4; `if_rdata`=0xDEADBEEF; `d_rdata` still 0.
- **Store:** `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`=0x12345678 -> `mem_wr`=1 in cycles 1..2 with `mem_wdata`=0x12345678; `d_done` in cycle 3; `d_rdata` unchanged.
- **Round-robin:** both `req` high from reset release -> fetch granted first (`if_done` at cycle 4), data granted next (`d_done` at cycle 9). A repeated tie then grants data before fetch.
- **Reset during store:** assert reset in the 2nd ACCESS cycle of a store -> `mem_wr` falls in the same cycle, no `d_done`. After release with `d_req` held, the store restarts and `d_done` follows 3 cycles later.
- **Minimum latency:** `MEM_LATENCY`=1, read `d_addr`=0x8 -> `d_done` in cycle 2 with the sampled `mem_rdata`; back-to-back second read gets `d_done` in cycle 5.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the shared instruction/data memory: inserts the
// fixed read/write wait states and returns a one-cycle done pulse per port.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate and capture a request
// ACCESS | memory address/data driven, wait-state counter running
// DONE   | owner's done pulse, memory write strobe released
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 3,
    parameter int WRITE_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       owner_d;      // 1 = data port owns the access in flight
    logic       last_grant_d; // 1 = data port was granted last
    logic       we_q;
    logic       grant_d;
    logic [3:0] term_cnt;

    always_comb begin
        grant_d = d_req;
        if (if_req && d_req) begin
            grant_d = ~last_grant_d;
        end
    end

    assign term_cnt  = we_q ? 4'(WRITE_CYCLES - 1) : 4'(MEM_LATENCY - 1);
    assign state_out = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            owner_d      <= 1'b0;
            last_grant_d <= 1'b1;
            we_q         <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wr       <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_d      <= grant_d;
                        last_grant_d <= grant_d;
                        we_q         <= grant_d & d_we;
                        mem_addr     <= grant_d ? d_addr : if_addr;
                        mem_wdata    <= grant_d ? d_wdata : '0;
                        mem_wr       <= grant_d & d_we;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == term_cnt) begin
                        if (!we_q) begin
                            if (owner_d) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        mem_wr  <= 1'b0;
                        if_done <= ~owner_d;
                        d_done  <= owner_d;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single-port accesses plus
// hand-written round-robin, reset-mid-store and minimum-latency sequences.
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_done, d_done, mem_wr, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]  state_out;

    logic        m_if_req, m_d_req, m_d_we;
    logic [31:0] m_if_addr, m_d_addr, m_d_wdata, m_mem_rdata;
    logic        m_if_done, m_d_done, m_mem_wr, m_busy;
    logic [31:0] m_if_rdata, m_d_rdata, m_mem_addr, m_mem_wdata;
    logic [1:0]  m_state_out;

    mem_port_arbiter u_dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy), .state_out(state_out)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) u_min (
        .clock(clock), .reset(reset),
        .if_req(m_if_req), .if_addr(m_if_addr), .if_done(m_if_done), .if_rdata(m_if_rdata),
        .d_req(m_d_req), .d_we(m_d_we), .d_addr(m_d_addr), .d_wdata(m_d_wdata),
        .d_done(m_d_done), .d_rdata(m_d_rdata),
        .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata), .mem_wr(m_mem_wr),
        .mem_rdata(m_mem_rdata), .busy(m_busy), .state_out(m_state_out)
    );

    typedef struct {
        logic        fetch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          done_cyc;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_d_rdata;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int          done_cyc;
        int          other_done;
        int          acc_err;
        logic        own;
        logic [31:0] cap_if, cap_d;
        logic [1:0]  cap_state;
        logic        cap_wr;
        done_cyc   = -1;
        other_done = 0;
        acc_err    = 0;
        cap_if     = 'x;
        cap_d      = 'x;
        cap_state  = 'x;
        cap_wr     = 1'bx;
        mem_rdata  = v.rdata;
        if (v.fetch) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            own = v.fetch ? if_done : d_done;
            if ((v.fetch ? d_done : if_done) === 1'b1) other_done++;
            if (cyc < v.done_cyc) begin
                if (mem_addr !== v.addr || mem_wr !== (!v.fetch && v.we) ||
                    busy !== 1'b1 || state_out !== 2'd1) acc_err++;
                if (!v.fetch && v.we && mem_wdata !== v.wdata) acc_err++;
            end
            if (cyc == v.done_cyc) begin
                cap_if    = if_rdata;
                cap_d     = d_rdata;
                cap_state = state_out;
                cap_wr    = mem_wr;
            end
            if (own === 1'b1) begin
                if (done_cyc < 0) done_cyc = cyc;
                else other_done++;
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check($sformatf("v%0d done_cycle", idx), 32'(done_cyc), 32'(v.done_cyc));
        check($sformatf("v%0d stray_done", idx), 32'(other_done), 32'd0);
        check($sformatf("v%0d access_phase", idx), 32'(acc_err), 32'd0);
        check($sformatf("v%0d if_rdata", idx), cap_if, v.exp_if_rdata);
        check($sformatf("v%0d d_rdata", idx), cap_d, v.exp_d_rdata);
        check($sformatf("v%0d done_state_wr", idx), {29'd0, cap_state, cap_wr}, {29'd0, 2'd2, 1'b0});
        check($sformatf("v%0d idle_after", idx), {30'd0, busy, state_out == 2'd0}, 32'd1);
    endtask

    initial begin
        vec_t vecs[5];
        int   if_c[2], d_c[2];
        int   n_if, n_d, d1, d2, rst_done;
        logic [31:0] r1, r2, a2;

        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 4, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h40, 32'h12345678, 32'hFFFFFFFF, 3, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h44, 32'h0,        32'hCAFEF00D, 4, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 1'b0, 32'h14, 32'h0,        32'h01020304, 4, 32'h01020304, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b1, 32'h48, 32'h55AA55AA, 32'h77777777, 3, 32'h01020304, 32'hCAFEF00D};

        if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        m_if_req = 0; m_d_req = 0; m_d_we = 0; m_if_addr = 0; m_d_addr = 0; m_d_wdata = 0;
        m_mem_rdata = 0;

        // Reset values, held while idle
        do_reset();
        repeat (5) tick();
        check("rst_ctrl", {27'd0, if_done, d_done, mem_wr, busy, state_out != 2'd0}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_vector(vecs[i], i);
        end

        // Round-robin with both requests held from reset release
        reset  = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h20;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        mem_rdata = 32'h11112222;
        tick();
        reset = 1'b1;
        n_if = 0; n_d = 0;
        if_c = '{-1, -1}; d_c = '{-1, -1};
        for (int cyc = 1; cyc <= 22; cyc++) begin
            tick();
            if (if_done === 1'b1) begin
                if (n_if < 2) if_c[n_if] = cyc;
                n_if++;
            end
            if (d_done === 1'b1) begin
                if (n_d < 2) d_c[n_d] = cyc;
                n_d++;
            end
            if (cyc == 19) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        check("rr_if_first", 32'(if_c[0]), 32'd4);
        check("rr_d_first", 32'(d_c[0]), 32'd9);
        check("rr_if_second", 32'(if_c[1]), 32'd14);
        check("rr_d_second", 32'(d_c[1]), 32'd19);
        check("rr_counts", 32'(n_if * 16 + n_d), 32'(2 * 16 + 2));

        // Reset in the second ACCESS cycle of a store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'hA0A0A0A0;
        tick();
        tick();
        check("rst_store_wr_before", {31'd0, mem_wr}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_store_wr_async", {29'd0, mem_wr, busy, state_out != 2'd0}, 32'd0);
        rst_done = 0;
        tick();
        if (d_done === 1'b1) rst_done++;
        reset = 1'b1;
        d1 = -1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (d_done === 1'b1) begin
                if (d1 < 0) d1 = cyc;
                else rst_done++;
                d_req = 1'b0;
            end
        end
        d_req = 1'b0;
        check("rst_store_no_done", 32'(rst_done), 32'd0);
        check("rst_store_restart", 32'(d1), 32'd3);

        // Minimum latency instance, back-to-back reads
        m_d_req = 1'b1; m_d_we = 1'b0; m_d_addr = 32'h8; m_mem_rdata = 32'hA5A5A5A5;
        d1 = -1; d2 = -1; r1 = 'x; r2 = 'x; a2 = 'x;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (cyc == 2) r1 = m_d_rdata;
            if (cyc == 4) a2 = m_mem_addr;
            if (cyc == 5) r2 = m_d_rdata;
            if (m_d_done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    m_d_addr = 32'hC;
                    m_mem_rdata = 32'h5A5A5A5A;
                end else if (d2 < 0) begin
                    d2 = cyc;
                    m_d_req = 1'b0;
                end
            end
        end
        m_d_req = 1'b0;
        check("min_done_first", 32'(d1), 32'd2);
        check("min_rdata_first", r1, 32'hA5A5A5A5);
        check("min_addr_second", a2, 32'hC);
        check("min_done_second", 32'(d2), 32'd5);
        check("min_rdata_second", r2, 32'h5A5A5A5A);
        check("min_if_rdata", m_if_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
